// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO special-register unit: opcodes, widths, FSM states.
package hilo_pkg;

    localparam int unsigned HILO_OP_W   = 3;
    localparam int unsigned HILO_DATA_W = 32;

    localparam logic [HILO_OP_W-1:0] HILO_NOP     = 3'd0;
    localparam logic [HILO_OP_W-1:0] HILO_WR_HI   = 3'd1;
    localparam logic [HILO_OP_W-1:0] HILO_WR_LO   = 3'd2;
    localparam logic [HILO_OP_W-1:0] HILO_WR_BOTH = 3'd3;
    localparam logic [HILO_OP_W-1:0] HILO_MADD    = 3'd4;
    localparam logic [HILO_OP_W-1:0] HILO_MSUB    = 3'd5;

    typedef enum logic {
        HILO_IDLE = 1'b0,
        HILO_BUSY = 1'b1
    } hilo_state_e;

endpackage

// File: rtl/hilo_acc_unit_if.sv
// Request/response bundle between the EX/MEM write-back path and the HI/LO unit.
interface hilo_acc_unit_if
    import hilo_pkg::*;
#(
    parameter int unsigned DATA_W = HILO_DATA_W
);

    logic                 op_valid;
    logic [HILO_OP_W-1:0] op;
    logic [DATA_W-1:0]    hi_i;
    logic [DATA_W-1:0]    lo_i;
    logic                 flush;
    logic                 op_ready;
    logic [DATA_W-1:0]    hi_o;
    logic [DATA_W-1:0]    lo_o;
    logic                 acc_done;
    logic                 ovf_o;

    modport master (
        output op_valid, op, hi_i, lo_i, flush,
        input  op_ready, hi_o, lo_o, acc_done, ovf_o
    );

    modport slave (
        input  op_valid, op, hi_i, lo_i, flush,
        output op_ready, hi_o, lo_o, acc_done, ovf_o
    );

endinterface

// File: rtl/hilo_acc_addsub.sv
// Combinational 2*DATA_W two's-complement add/subtract with signed-overflow detect.
module hilo_acc_addsub #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] p,
    input  logic         sub,
    output logic [W-1:0] sum_c,
    output logic         ovf_c
);

    logic a_s;
    logic p_s;
    logic r_s;

    always_comb begin
        sum_c = sub ? (a - p) : (a + p);
        a_s   = a[W-1];
        p_s   = p[W-1];
        r_s   = sum_c[W-1];
        // Subtract compares against P's own sign so a most-negative P still flags.
        if (sub) begin
            ovf_c = (a_s != p_s) && (r_s != a_s);
        end else begin
            ovf_c = (a_s == p_s) && (r_s != a_s);
        end
    end

endmodule

// File: rtl/hilo_acc_unit.sv
// Architectural HI/LO pair with direct writes and two-cycle MADD/MSUB accumulate.
module hilo_acc_unit
    import hilo_pkg::*;
#(
    parameter int unsigned DATA_W = HILO_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    hilo_acc_unit_if.slave  bus
);

    localparam int unsigned ACC_W = 2 * DATA_W;

    hilo_state_e        state_q, state_d;
    logic [DATA_W-1:0]  hi_q, hi_d;
    logic [DATA_W-1:0]  lo_q, lo_d;
    logic [ACC_W-1:0]   p_q, p_d;
    logic               sub_q, sub_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;

    logic               accept_c;
    logic [ACC_W-1:0]   sum_c;
    logic               ovf_c;

    hilo_acc_addsub #(
        .W (ACC_W)
    ) u_addsub (
        .a     ({hi_q, lo_q}),
        .p     (p_q),
        .sub   (sub_q),
        .sum_c (sum_c),
        .ovf_c (ovf_c)
    );

    assign accept_c = bus.op_valid && (state_q == HILO_IDLE) && !bus.flush;

    // State, HI/LO, stage and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HILO_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            p_q     <= '0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            p_q     <= p_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath selection
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        p_d     = p_q;
        sub_d   = sub_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            HILO_IDLE: begin
                if (accept_c) begin
                    case (bus.op)
                        HILO_WR_HI: hi_d = bus.hi_i;
                        HILO_WR_LO: lo_d = bus.lo_i;
                        HILO_WR_BOTH: begin
                            hi_d  = bus.hi_i;
                            lo_d  = bus.lo_i;
                            ovf_d = 1'b0;
                        end
                        HILO_MADD, HILO_MSUB: begin
                            p_d     = {bus.hi_i, bus.lo_i};
                            sub_d   = (bus.op == HILO_MSUB);
                            state_d = HILO_BUSY;
                        end
                        default: ;
                    endcase
                end
            end
            HILO_BUSY: begin
                state_d = HILO_IDLE;
                // A flush here cancels the commit entirely.
                if (!bus.flush) begin
                    hi_d   = sum_c[ACC_W-1:DATA_W];
                    lo_d   = sum_c[DATA_W-1:0];
                    done_d = 1'b1;
                    if (ovf_c) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: state_d = HILO_IDLE;
        endcase
    end

    assign bus.op_ready = (state_q == HILO_IDLE);
    assign bus.hi_o     = hi_q;
    assign bus.lo_o     = lo_q;
    assign bus.acc_done = done_q;
    assign bus.ovf_o    = ovf_q;

endmodule
